// File: rtl/axis_udp_gen_frame_if.sv
// Beat bundle between the UDP frame source and the AXIS control stage.
// en is the downstream tready; a beat moves when data_valid & en.
interface axis_udp_gen_frame_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  frame_end;
    logic                  en;

    modport master (
        output data,
        output data_valid,
        output frame_end,
        input  en
    );

    modport slave (
        input  data,
        input  data_valid,
        input  frame_end,
        output en
    );
endinterface

// File: rtl/axis_udp_gen_frame.sv
// Ethernet II + IPv4 + UDP frame source on a 64-bit beat bus, incrementing payload,
// in-block IPv4 header checksum, optional idle gap between frames.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no frame in flight, waiting for gen_en_i
// ST_SEND | presenting beats 0..4+N, advancing on each transfer
// ST_GAP  | data_valid low, down-counting the latched inter-frame gap
module axis_udp_gen_frame #(
    parameter int DATA_WIDTH = 64,
    parameter int TTL        = 64
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  gen_en_i,
    input  logic [7:0]            frame_gap_i,
    input  logic [7:0]            payload_words_i,
    input  logic [47:0]           dst_mac_i,
    input  logic [47:0]           src_mac_i,
    input  logic [31:0]           src_ip_i,
    input  logic [31:0]           dst_ip_i,
    input  logic [15:0]           src_port_i,
    input  logic [15:0]           dst_port_i,
    axis_udp_gen_frame_if.master  m_if,
    output logic                  busy_o,
    output logic [31:0]           frame_cnt_o
);

    localparam logic [7:0] TTL_B = 8'(TTL);

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [7:0]  n;
    } cfg_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t                r_state;
    cfg_t                  r_cfg;
    logic [7:0]            r_gap;
    logic [7:0]            r_gap_cnt;
    logic [8:0]            r_beat;
    logic [8:0]            r_last;
    logic [15:0]           r_ip_id;
    logic [15:0]           r_csum;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_end;
    logic                  r_busy;
    logic [31:0]           r_frame_cnt;

    cfg_t        w_cfg_in;
    logic [15:0] w_tl;
    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;
    logic [15:0] w_csum;
    logic [8:0]  w_beat_nxt;
    logic        w_last_xfer;
    logic        w_gap_done;
    logic        w_start;

    // Frame bytes 0..41 are the packed header; anything beyond is (n-42) mod 256.
    function automatic logic [63:0] f_beat(input logic [8:0] b, input cfg_t c,
                                           input logic [15:0] id, input logic [15:0] cs);
        logic [335:0] hdr;
        logic [15:0]  tl;
        logic [15:0]  ul;
        logic [11:0]  n;
        tl  = 16'd26 + {5'd0, c.n, 3'd0};
        ul  = 16'd6 + {5'd0, c.n, 3'd0};
        hdr = {c.dst_mac, c.src_mac, 16'h0800, 8'h45, 8'h00, tl, id, 16'h4000,
               TTL_B, 8'h11, cs, c.src_ip, c.dst_ip, c.src_port, c.dst_port, ul, 16'h0000};
        f_beat = '0;
        for (int k = 0; k < 8; k++) begin
            n = {b, 3'b000} + 12'(k);
            if (n < 12'd42)
                f_beat[8*k +: 8] = 8'(hdr >> (13'd328 - {4'd0, n[5:0], 3'b000}));
            else
                f_beat[8*k +: 8] = n[7:0] - 8'd42;
        end
    endfunction

    always_comb begin
        w_cfg_in          = '0;
        w_cfg_in.dst_mac  = dst_mac_i;
        w_cfg_in.src_mac  = src_mac_i;
        w_cfg_in.src_ip   = src_ip_i;
        w_cfg_in.dst_ip   = dst_ip_i;
        w_cfg_in.src_port = src_port_i;
        w_cfg_in.dst_port = dst_port_i;
        w_cfg_in.n        = (payload_words_i == 8'd0) ? 8'd1 : payload_words_i;
    end

    // Registered checksum tracks the latched config; it settles two edges after
    // a frame starts, well before beat 3 is loaded.
    assign w_tl    = 16'd26 + {5'd0, r_cfg.n, 3'd0};
    assign w_sum   = 20'h04500 + 20'(w_tl) + 20'(r_ip_id) + 20'h04000
                   + 20'({TTL_B, 8'h11})
                   + 20'(r_cfg.src_ip[31:16]) + 20'(r_cfg.src_ip[15:0])
                   + 20'(r_cfg.dst_ip[31:16]) + 20'(r_cfg.dst_ip[15:0]);
    assign w_fold1 = {1'b0, w_sum[15:0]} + 17'(w_sum[19:16]);
    assign w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
    assign w_csum  = ~w_fold2;

    assign w_beat_nxt  = r_beat + 9'd1;
    assign w_last_xfer = (r_state == ST_SEND) && m_if.en && r_end;
    assign w_gap_done  = (r_state == ST_GAP) && (r_gap_cnt == 8'd0);
    assign w_start     = gen_en_i && ((r_state == ST_IDLE)
                                   || (w_last_xfer && (r_gap == 8'd0))
                                   || w_gap_done);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state     <= ST_IDLE;
            r_cfg       <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_beat      <= '0;
            r_last      <= '0;
            r_ip_id     <= '0;
            r_csum      <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_end       <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_csum <= w_csum;
            if (w_last_xfer) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
                r_ip_id     <= r_ip_id + 16'd1;
            end
            if (w_start) begin
                r_state <= ST_SEND;
                r_cfg   <= w_cfg_in;
                r_gap   <= frame_gap_i;
                r_beat  <= '0;
                r_last  <= 9'd4 + {1'b0, w_cfg_in.n};
                r_data  <= f_beat(9'd0, w_cfg_in, 16'd0, 16'd0);
                r_valid <= 1'b1;
                r_end   <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    ST_SEND: begin
                        if (w_last_xfer) begin
                            r_data  <= '0;
                            r_valid <= 1'b0;
                            r_end   <= 1'b0;
                            if (r_gap != 8'd0) begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= r_gap - 8'd1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else if (m_if.en) begin
                            r_beat <= w_beat_nxt;
                            r_data <= f_beat(w_beat_nxt, r_cfg, r_ip_id, r_csum);
                            r_end  <= (w_beat_nxt == r_last);
                        end
                    end
                    ST_GAP: begin
                        if (w_gap_done) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign m_if.data       = r_data;
    assign m_if.data_valid = r_valid;
    assign m_if.frame_end  = r_end;
    assign busy_o          = r_busy;
    assign frame_cnt_o     = r_frame_cnt;

endmodule

// File: tb/tb_axis_udp_gen_frame.sv
// Directed bench for axis_udp_gen_frame: single frame, back-pressure, back-to-back,
// gap, stop with config change, and reset mid-frame.
module tb_axis_udp_gen_frame;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        gen_en = 1'b0;
    logic [7:0]  frame_gap = 8'd0;
    logic [7:0]  payload_words = 8'd1;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = '0;
    logic [31:0] src_ip = '0;
    logic [31:0] dst_ip = '0;
    logic [15:0] src_port = '0;
    logic [15:0] dst_port = '0;
    logic        busy;
    logic [31:0] frame_cnt;

    axis_udp_gen_frame_if #(.DATA_WIDTH(64)) bus ();

    axis_udp_gen_frame #(.DATA_WIDTH(64), .TTL(64)) dut (
        .clk_i           (clk),
        .arst_n_i        (arst_n),
        .gen_en_i        (gen_en),
        .frame_gap_i     (frame_gap),
        .payload_words_i (payload_words),
        .dst_mac_i       (dst_mac),
        .src_mac_i       (src_mac),
        .src_ip_i        (src_ip),
        .dst_ip_i        (dst_ip),
        .src_port_i      (src_port),
        .dst_port_i      (dst_port),
        .m_if            (bus.master),
        .busy_o          (busy),
        .frame_cnt_o     (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // expected-side copy of the config latched for the frame under test
    logic [47:0] e_dst_mac, e_src_mac;
    logic [31:0] e_src_ip, e_dst_ip;
    logic [15:0] e_sport, e_dport;
    int          e_n;
    logic [15:0] exp_id = 16'd0;
    logic [31:0] exp_cnt = 32'd0;
    logic [63:0] cap [0:263];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] n, input logic [7:0] gap, input logic [15:0] dport);
        dst_mac = 48'h02_11_22_33_44_55; src_mac = 48'h02_66_77_88_99_AA;
        src_ip = 32'hC0A8_010A; dst_ip = 32'hC0A8_0101;
        src_port = 16'h1000; dst_port = dport;
        payload_words = n; frame_gap = gap;
        e_dst_mac = dst_mac; e_src_mac = src_mac; e_src_ip = src_ip; e_dst_ip = dst_ip;
        e_sport = src_port; e_dport = dport;
        e_n = (n == 8'd0) ? 1 : int'(n);
    endtask

    function automatic logic [15:0] ref_csum();
        logic [15:0] w [10];
        logic [16:0] s;
        w[0] = 16'h4500; w[1] = 16'(26 + 8*e_n); w[2] = exp_id; w[3] = 16'h4000;
        w[4] = 16'h4011; w[5] = 16'h0000;
        w[6] = e_src_ip[31:16]; w[7] = e_src_ip[15:0];
        w[8] = e_dst_ip[31:16]; w[9] = e_dst_ip[15:0];
        s = 17'd0;
        for (int i = 0; i < 10; i++) begin
            s = {1'b0, s[15:0]} + {1'b0, w[i]};
            s = {1'b0, s[15:0]} + {16'd0, s[16]};
        end
        return ~s[15:0];
    endfunction

    function automatic logic [7:0] ref_byte(input int n);
        logic [15:0] tl, ul, cs;
        tl = 16'(26 + 8*e_n);
        ul = 16'(6 + 8*e_n);
        cs = ref_csum();
        if (n >= 42)             return 8'((n - 42) % 256);
        if (n <= 5)              return e_dst_mac[8*(5-n) +: 8];
        if (n <= 11)             return e_src_mac[8*(11-n) +: 8];
        if (n >= 26 && n <= 29)  return e_src_ip[8*(29-n) +: 8];
        if (n >= 30 && n <= 33)  return e_dst_ip[8*(33-n) +: 8];
        case (n)
            12: return 8'h08;
            14: return 8'h45;
            16: return tl[15:8];
            17: return tl[7:0];
            18: return exp_id[15:8];
            19: return exp_id[7:0];
            20: return 8'h40;
            22: return 8'd64;
            23: return 8'h11;
            24: return cs[15:8];
            25: return cs[7:0];
            34: return e_sport[15:8];
            35: return e_sport[7:0];
            36: return e_dport[15:8];
            37: return e_dport[7:0];
            38: return ul[15:8];
            39: return ul[7:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [63:0] ref_beat(input int b);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_byte(8*b + k);
        return r;
    endfunction

    // Follows one frame beat by beat; on drop_at the generator is disabled and the
    // destination port is changed, neither of which may affect the frame in flight.
    task automatic run_frame(input string tg, input bit rnd, input int drop_at);
        int  guard, b, last;
        bit  e, dropped;
        guard = 0;
        while (!bus.data_valid && guard < 300) begin
            tick();
            guard++;
        end
        chk({tg, " start"}, bus.data_valid, 1'b1);
        last = 4 + e_n;
        b = 0;
        dropped = 0;
        guard = 0;
        while (b <= last && guard < 3000) begin
            if (b == drop_at && !dropped) begin
                gen_en = 1'b0;
                dst_port = ~dst_port;
                dropped = 1;
            end
            e = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.en = e;
            chk($sformatf("%s b%0d data", tg, b), bus.data, ref_beat(b));
            chk($sformatf("%s b%0d end", tg, b), bus.frame_end, (b == last));
            chk($sformatf("%s b%0d valid", tg, b), bus.data_valid, 1'b1);
            if (e) cap[b] = bus.data;
            tick();
            guard++;
            if (e) b++;
        end
        if (b <= last) chk({tg, " timeout"}, 64'(b), 64'(last + 1));
        bus.en = 1'b1;
        exp_id++;
        exp_cnt++;
        chk({tg, " frame_cnt"}, frame_cnt, exp_cnt);
    endtask

    initial begin
        int g;
        bus.en = 1'b1;
        set_cfg(8'd1, 8'd0, 16'h2000);
        repeat (3) tick();
        chk("rst data", bus.data, 64'd0);
        chk("rst valid", bus.data_valid, 1'b0);
        chk("rst end", bus.frame_end, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst cnt", frame_cnt, 32'd0);
        arst_n = 1'b1;
        tick();

        // single frame, N=1
        gen_en = 1'b1;
        run_frame("single", 1'b0, 0);
        chk("single tot_len", {cap[2][7:0], cap[2][15:8]}, 16'h0022);
        chk("single udp_len", {cap[4][55:48], cap[4][63:56]}, 16'h000E);
        chk("single beat3", cap[3], 64'hA8C00A01A8C06FB7);
        chk("single beat5 pay", cap[5][63:16], 48'h050403020100);
        repeat (3) tick();
        chk("single idle busy", busy, 1'b0);
        chk("single idle valid", bus.data_valid, 1'b0);

        // back-pressure, N=4
        set_cfg(8'd4, 8'd0, 16'h2000);
        gen_en = 1'b1;
        run_frame("bp", 1'b1, 0);
        chk("bp beat8", cap[8], 64'h1D1C1B1A19181716);
        chk("bp beat5", cap[5], 64'h0504030201000000);
        repeat (2) tick();

        // back-to-back from a fresh reset: IDs 0,1,2
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        exp_id = 16'd0;
        exp_cnt = 32'd0;
        set_cfg(8'd1, 8'd0, 16'h2000);
        gen_en = 1'b1;
        run_frame("b2b0", 1'b0, -1);
        chk("b2b0 csum", {cap[3][7:0], cap[3][15:8]}, 16'hB76F);
        chk("b2b0 valid after", bus.data_valid, 1'b1);
        run_frame("b2b1", 1'b0, -1);
        chk("b2b1 csum", {cap[3][7:0], cap[3][15:8]}, 16'hB76E);
        chk("b2b1 id", {cap[2][23:16], cap[2][31:24]}, 16'd1);
        chk("b2b1 valid after", bus.data_valid, 1'b1);
        run_frame("b2b2", 1'b0, 0);
        chk("b2b2 csum", {cap[3][7:0], cap[3][15:8]}, 16'hB76D);
        chk("b2b2 id", {cap[2][23:16], cap[2][31:24]}, 16'd2);
        chk("b2b cnt", frame_cnt, 32'd3);
        repeat (2) tick();

        // gap of 5, N=0 treated as 1
        set_cfg(8'd0, 8'd5, 16'h2000);
        gen_en = 1'b1;
        run_frame("gapA", 1'b0, -1);
        g = 0;
        while (!bus.data_valid && g < 50) begin
            g++;
            tick();
        end
        chk("gap idle cycles", 64'(g), 64'd5);
        run_frame("gapB", 1'b0, 0);
        repeat (8) tick();

        // stop and dst_port change at beat 2
        set_cfg(8'd2, 8'd0, 16'h1234);
        gen_en = 1'b1;
        run_frame("stop", 1'b0, 2);
        chk("stop old port", {cap[4][39:32], cap[4][47:40]}, 16'h1234);
        tick();
        chk("stop busy", busy, 1'b0);
        chk("stop valid", bus.data_valid, 1'b0);

        // reset asserted while beat 3 is presented
        set_cfg(8'd2, 8'd0, 16'h2000);
        gen_en = 1'b1;
        g = 0;
        while (!bus.data_valid && g < 50) begin
            g++;
            tick();
        end
        chk("rmid start", bus.data_valid, 1'b1);
        repeat (3) tick();
        chk("rmid beat3", bus.data, ref_beat(3));
        arst_n = 1'b0;
        #1;
        chk("rmid data", bus.data, 64'd0);
        chk("rmid valid", bus.data_valid, 1'b0);
        chk("rmid end", bus.frame_end, 1'b0);
        chk("rmid busy", busy, 1'b0);
        chk("rmid cnt", frame_cnt, 32'd0);
        gen_en = 1'b0;
        tick();
        arst_n = 1'b1;
        exp_id = 16'd0;
        exp_cnt = 32'd0;
        tick();
        chk("post rst cnt", frame_cnt, 32'd0);
        gen_en = 1'b1;
        run_frame("post", 1'b0, 0);
        chk("post id", {cap[2][23:16], cap[2][31:24]}, 16'd0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
